// File: rtl/eg2000_tape_pkg.sv
// Shared types and defaults for the EG2000 cassette recorder decoder.
// The cell FSM times pulse intervals. The byte FSM aligns and frames the bits.
package eg2000_tape_pkg;

  localparam int         CNT_W         = 13;
  localparam int         WIN_LO_DEF    = 1200;
  localparam int         WIN_HI_DEF    = 2600;
  localparam int         TIMEOUT_DEF   = 8000;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic {
    GAP,
    CELL
  } cell_state_t;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    SYNCED
  } byte_state_t;

endpackage

// File: rtl/tape_rec_decoder_if.sv
// Tape RAM second write port.
// Handshake: ram_we is a one-clock write strobe with no ready. The RAM port always
// accepts, and ram_a/ram_d are valid in the same clock that ram_we is high.
interface tape_rec_decoder_if #(
  parameter int ADDR_W = 16
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_d;

  modport master (output ram_we, ram_a, ram_d);
  modport slave  (input  ram_we, ram_a, ram_d);
endinterface

// File: rtl/tape_pulse_timer.sv
// Pulse edge detector, saturating interval counter and cell FSM.
// Each cell yields one bit: 1 if a data pulse landed inside the window.
module tape_pulse_timer
  import eg2000_tape_pkg::*;
#(
  parameter int WIN_LO  = WIN_LO_DEF,
  parameter int WIN_HI  = WIN_HI_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        clear,
  input  logic [1:0]  level,
  output logic        bit_valid,
  output logic        bit_val,
  output cell_state_t cell_state
);

  localparam logic [CNT_W-1:0] LO    = CNT_W'(WIN_LO);
  localparam logic [CNT_W-1:0] HI    = CNT_W'(WIN_HI);
  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  logic [1:0]       level_q;
  logic [CNT_W-1:0] cnt;
  logic             one_seen;
  logic             pulse;
  logic             late;
  logic             in_win;
  logic             expire;

  // A pulse is only the rise from silence; 01->10 is the same pulse continuing.
  assign pulse  = ce && (level != 2'b00) && (level_q == 2'b00);
  assign late   = cnt > HI;
  assign in_win = (cnt >= LO) && !late;
  assign expire = ce && !pulse && (cnt >= TO_M1);

  // The decision is combinational so the byte logic registers it on the same edge.
  always_comb begin
    bit_valid = 1'b0;
    bit_val   = one_seen;
    if (!clear && cell_state == CELL && ((pulse && late) || expire)) begin
      bit_valid = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q    <= 2'b00;
      cnt        <= '0;
      one_seen   <= 1'b0;
      cell_state <= GAP;
    end else begin
      if (ce) begin
        level_q <= level;
      end
      if (clear) begin
        cnt        <= '0;
        one_seen   <= 1'b0;
        cell_state <= GAP;
      end else if (ce) begin
        if (cnt != TO) begin
          cnt <= cnt + 1'b1;
        end
        case (cell_state)
          GAP: begin
            if (pulse) begin
              cnt        <= '0;
              one_seen   <= 1'b0;
              cell_state <= CELL;
            end
          end
          CELL: begin
            if (pulse) begin
              if (late) begin
                cnt      <= '0;
                one_seen <= 1'b0;
              end else if (in_win) begin
                one_seen <= 1'b1;
              end
            end else if (expire) begin
              cell_state <= GAP;
            end
          end
          default: cell_state <= GAP;
        endcase
      end
    end
  end

endmodule

// File: rtl/tape_rec_decoder.sv
// Cassette save decoder: turns port $FF pulse trains into .CAS bytes in tape RAM.
// Hunts for the sync byte, then frames every 8 recovered bits into one write.
module tape_rec_decoder
  import eg2000_tape_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter int         WIN_LO    = WIN_LO_DEF,
  parameter int         WIN_HI    = WIN_HI_DEF,
  parameter int         TIMEOUT   = TIMEOUT_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  motor,
  input  logic [1:0]            level,
  tape_rec_decoder_if.master    ram,
  output logic [ADDR_W-1:0]     rec_len,
  output logic                  busy,
  output logic                  synced,
  output logic                  overflow,
  output byte_state_t           dbg_byte_state,
  output cell_state_t           dbg_cell_state
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  byte_state_t       state;
  logic              motor_q;
  logic              motor_rise;
  logic [7:0]        shift;
  logic [7:0]        shift_nx;
  logic [2:0]        bitcnt;
  logic [ADDR_W-1:0] ptr;
  logic              bit_valid;
  logic              bit_val;
  logic              wr_req;

  assign motor_rise     = motor && !motor_q;
  assign shift_nx       = {shift[6:0], bit_val};
  assign rec_len        = ptr;
  assign synced         = (state == SYNCED);
  assign dbg_byte_state = state;

  tape_pulse_timer #(
    .WIN_LO  (WIN_LO),
    .WIN_HI  (WIN_HI),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .clear      (motor_rise),
    .level      (level),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val),
    .cell_state (dbg_cell_state)
  );

  // Motor-off on the completing edge wins, so the request is gated by motor.
  always_comb begin
    wr_req = 1'b0;
    if (motor && !motor_rise && bit_valid) begin
      if (state == HUNT && shift_nx == SYNC_BYTE) begin
        wr_req = 1'b1;
      end
      if (state == SYNCED && bitcnt == 3'd7) begin
        wr_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      motor_q    <= 1'b0;
      busy       <= 1'b0;
      shift      <= 8'h00;
      bitcnt     <= 3'd0;
      ptr        <= '0;
      overflow   <= 1'b0;
      ram.ram_we <= 1'b0;
      ram.ram_a  <= '0;
      ram.ram_d  <= 8'h00;
    end else begin
      motor_q    <= motor;
      busy       <= motor;
      ram.ram_we <= 1'b0;

      // The last address is written once; ptr then parks there while overflow holds.
      if (ram.ram_we) begin
        if (ptr == PTR_MAX) begin
          overflow <= 1'b1;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end

      if (wr_req && !overflow && !ram.ram_we) begin
        ram.ram_we <= 1'b1;
        ram.ram_a  <= ptr;
        ram.ram_d  <= shift_nx;
      end

      if (!motor) begin
        state <= IDLE;
      end else if (motor_rise) begin
        state    <= HUNT;
        ptr      <= '0;
        overflow <= 1'b0;
        shift    <= 8'h00;
        bitcnt   <= 3'd0;
      end else if (bit_valid) begin
        case (state)
          HUNT: begin
            shift <= shift_nx;
            if (shift_nx == SYNC_BYTE) begin
              state  <= SYNCED;
              bitcnt <= 3'd0;
            end
          end
          SYNCED: begin
            shift  <= shift_nx;
            bitcnt <= bitcnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tape_rec_decoder.sv
// Bench for tape_rec_decoder: random pulse-train cells feed a bit-level model.
// A monitor pops expected {addr,data} writes from a queue.
module tb_tape_rec_decoder;
  import eg2000_tape_pkg::*;

  localparam int ADDR_W  = 4;
  localparam int WIN_LO  = 12;
  localparam int WIN_HI  = 26;
  localparam int TIMEOUT = 80;
  localparam int W       = ADDR_W + 8;
  localparam int NSLOTS  = 1 << ADDR_W;

  logic        clock;
  logic        reset;
  logic        ce;
  logic        motor;
  logic [1:0]  level;
  logic [ADDR_W-1:0] rec_len;
  logic        busy;
  logic        synced;
  logic        overflow;
  byte_state_t dbg_byte_state;
  cell_state_t dbg_cell_state;

  tape_rec_decoder_if #(.ADDR_W(ADDR_W)) ram_bus ();

  tape_rec_decoder #(
    .ADDR_W    (ADDR_W),
    .WIN_LO    (WIN_LO),
    .WIN_HI    (WIN_HI),
    .TIMEOUT   (TIMEOUT),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ce             (ce),
    .motor          (motor),
    .level          (level),
    .ram            (ram_bus.master),
    .rec_len        (rec_len),
    .busy           (busy),
    .synced         (synced),
    .overflow       (overflow),
    .dbg_byte_state (dbg_byte_state),
    .dbg_cell_state (dbg_cell_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  bit   bits_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ce_num = 0;
  int   last_sync_ce = 0;
  int   last_write_ce = 0;
  int   m_wr = 0;
  bit   m_synced = 0;
  bit   pend_v = 0;
  bit   pend_b = 0;
  logic prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void model_write(input logic [7:0] v);
    if (m_wr < NSLOTS) begin
      exp_q.push_back({ADDR_W'(m_wr), v});
      m_wr++;
    end
  endfunction

  // Before sync, a sliding 8-bit window is searched for A5. After sync, bits are grouped by 8.
  function automatic void model_bit(input bit b);
    logic [7:0] v;
    bits_q.push_back(b);
    if (!m_synced && bits_q.size() > 8) void'(bits_q.pop_front());
    if (bits_q.size() == 8) begin
      v = 8'h00;
      foreach (bits_q[i]) v = (v << 1) | 8'(bits_q[i]);
      if (m_synced || v == 8'hA5) begin
        m_synced = 1;
        model_write(v);
        bits_q.delete();
      end
    end
  endfunction

  // Driver tasks
  task automatic wait_clocks(input int n);
    ce = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ce_step(input logic [1:0] lvl);
    int gap;
    gap = $urandom_range(0, 1);
    ce = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    level = lvl;
    ce = 1'b1;
    @(posedge clock);
    ce_num++;
    #1;
    ce = 1'b0;
  endtask

  // One cell: sync pulse at 0, optional glitch, data pulse if b, next sync after len.
  task automatic send_cell(input bit b, input int dpos, input int len_in);
    logic [1:0] lv [0:63];
    int len, p, w;
    len = (len_in != 0) ? len_in : int'($urandom_range(28, 40));
    for (int i = 0; i < 64; i++) lv[i] = 2'b00;
    w = $urandom_range(1, 3);
    for (int j = 0; j < w; j++) lv[j] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 1) == 1) begin
      p = $urandom_range(4, 8);
      w = $urandom_range(1, 2);
      for (int j = 0; j < w; j++) lv[p+j] = 2'($urandom_range(1, 3));
    end
    if (b) begin
      p = (dpos != 0) ? dpos : int'($urandom_range(13, 23));
      w = (dpos != 0) ? 1 : int'($urandom_range(1, 3));
      for (int j = 0; j < w; j++) lv[p+j] = 2'($urandom_range(1, 3));
    end
    if (pend_v) model_bit(pend_b);
    pend_v = 1;
    pend_b = b;
    last_sync_ce = ce_num + 1;
    for (int i = 0; i < len; i++) ce_step(lv[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_cell(v[i], 0, 0);
  endtask

  task automatic silence(input int n);
    if (pend_v) model_bit(pend_b);
    pend_v = 0;
    repeat (n) ce_step(2'b00);
  endtask

  task automatic motor_on();
    motor = 1'b1;
    m_wr = 0;
    m_synced = 0;
    pend_v = 0;
    bits_q.delete();
    wait_clocks(2);
  endtask

  task automatic motor_off();
    motor = 1'b0;
    m_synced = 0;
    pend_v = 0;
    bits_q.delete();
    wait_clocks(2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},       32'(ram_bus.ram_we), 0);
    check({tag, "_a"},        32'(ram_bus.ram_a),  0);
    check({tag, "_d"},        32'(ram_bus.ram_d),  0);
    check({tag, "_rec_len"},  32'(rec_len),        0);
    check({tag, "_busy"},     32'(busy),           0);
    check({tag, "_synced"},   32'(synced),         0);
    check({tag, "_overflow"}, 32'(overflow),       0);
  endtask

  // Monitor
  always @(negedge clock) begin
    logic [W-1:0] exp;
    if (reset && ram_bus.ram_we) begin
      check("we_single_clock", 32'(prev_we), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got a=%0h d=%0h exp=none", ram_bus.ram_a, ram_bus.ram_d);
      end else begin
        exp = exp_q.pop_front();
        check("write", 32'({ram_bus.ram_a, ram_bus.ram_d}), 32'(exp));
        last_write_ce = ce_num;
      end
    end
    prev_we = ram_bus.ram_we;
  end

  // Stimulus
  initial begin
    reset = 1'b0;
    ce    = 1'b0;
    motor = 1'b0;
    level = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    check("reset_byte_state", 32'(dbg_byte_state), 32'(IDLE));
    check("reset_cell_state", 32'(dbg_cell_state), 32'(GAP));
    reset = 1'b1;
    wait_clocks(2);

    // Leader of zeros, sync, one data byte, then long silence
    motor_on();
    check("on_busy", 32'(busy), 1);
    check("on_state", 32'(dbg_byte_state), 32'(HUNT));
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h55);
    silence(TIMEOUT + 40);
    check("main_rec_len", 32'(rec_len), 2);
    check("main_synced", 32'(synced), 1);
    check("main_drained", 32'(exp_q.size()), 0);

    // Window edges at cnt=WIN_LO and cnt=WIN_HI, then a final 0xFF closed by timeout
    send_cell(1, 13, 0);
    send_cell(1, 27, 40);
    send_cell(0, 0, 0);
    send_cell(0, 0, 0);
    send_cell(0, 0, 0);
    send_cell(0, 0, 0);
    send_cell(1, 0, 0);
    send_cell(1, 0, 0);
    send_byte(8'($urandom));
    send_byte(8'hFF);
    silence(TIMEOUT + 10);
    check("timeout_latency", 32'(last_write_ce - last_sync_ce), TIMEOUT);
    check("timeout_rec_len", 32'(rec_len), 32'(m_wr));
    check("timeout_drained", 32'(exp_q.size()), 0);

    // Motor drops after 5 bits of a byte
    motor_off();
    motor_on();
    check("restart_rec_len", 32'(rec_len), 0);
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_cell(1'($urandom), 0, 0);
    motor_off();
    silence(TIMEOUT + 10);
    check("off_state", 32'(dbg_byte_state), 32'(IDLE));
    check("off_rec_len", 32'(rec_len), 1);
    check("off_busy", 32'(busy), 0);
    check("off_synced", 32'(synced), 0);
    check("off_drained", 32'(exp_q.size()), 0);
    motor_on();
    check("rerise_rec_len", 32'(rec_len), 0);
    check("rerise_state", 32'(dbg_byte_state), 32'(HUNT));

    // RAM fill: 20 bytes after sync, only 2^ADDR_W writes land
    send_byte(8'hA5);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    silence(TIMEOUT + 10);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drained", 32'(exp_q.size()), 0);
    send_byte(8'($urandom));
    silence(TIMEOUT + 10);
    check("ovf_still", 32'(overflow), 1);
    motor_off();
    motor_on();
    check("ovf_cleared", 32'(overflow), 0);
    check("ovf_ptr_cleared", 32'(rec_len), 0);

    // Reset lands while the sync-byte write strobe is high
    send_byte(8'hA5);
    ce_step(2'b01);
    check("pre_reset_we", 32'(ram_bus.ram_we), 1);
    check("pre_reset_a", 32'(ram_bus.ram_a), 0);
    check("pre_reset_d", 32'(ram_bus.ram_d), 32'h00A5);
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    level = 2'b00;
    exp_q.delete();
    bits_q.delete();
    pend_v = 0;
    m_wr = 0;
    m_synced = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_clocks(2);
    check("post_reset_state", 32'(dbg_byte_state), 32'(HUNT));
    send_byte(8'h00);
    send_byte(8'h00);
    silence(TIMEOUT + 10);
    check("post_reset_rec_len", 32'(rec_len), 0);
    check("post_reset_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tape_rec_decoder.md
# tape_rec_decoder

Cassette recorder decoder for the EG2000/Colour Genie core. It consumes the CPU's port $FF cassette output level, which is the pulse train written by the Level II save routine, and recovers the bit stream from pulse intervals. It byte-aligns on the sync byte and writes the recovered .CAS bytes into the tape RAM so a save can be uploaded by the host. It sits downstream of the port $FF write latch (`tapebits`) and upstream of the tape RAM's second write port.

## Interface
Parameters:
- `ADDR_W`, 16: tape RAM address width; capacity 2^ADDR_W bytes.
- `WIN_LO`, 1200: minimum CPU cycles after sync for a data pulse.
- `WIN_HI`, 2600: maximum CPU cycles after sync for a data pulse.
- `TIMEOUT`, 8000: CPU cycles without a pulse that close the current cell.
- `SYNC_BYTE`, 8'hA5: alignment pattern.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low.
- `ce`  in  1: CPU cycle enable (pe2M2); all counting is gated by it.
- `motor`  in  1: tape motor bit (`tapebits[2]`).
- `level`  in  2: cassette output level (`tapebits[1:0]`).
- `ram_we`  out  1: one-clock write strobe.
- `ram_a`  out  ADDR_W: write address.
- `ram_d`  out  8: write data.
- `rec_len`  out  ADDR_W: bytes written since the last motor-on.
- `busy`  out  1: motor on and recording.
- `synced`  out  1: sync byte found.
- `overflow`  out  1: sticky; RAM full.

## Operation
- **Pulse detection.** `level` is sampled on each `ce`. A pulse is `level != 0` while the previous sample was 0. Transitions 01→10 are not pulses.
- **Interval counter.** 13 bits. Increments on `ce` and saturates at `TIMEOUT`.
- **Cell FSM** (`GAP`, `CELL`), with a per-cell `one_seen` flag:
  - `GAP` + pulse → `CELL`, cnt=0, one_seen=0. No bit is emitted.
  - `CELL` + pulse with cnt < WIN_LO → ignored (glitch).
  - `CELL` + pulse with WIN_LO ≤ cnt ≤ WIN_HI → one_seen=1. cnt is not cleared.
  - `CELL` + pulse with cnt > WIN_HI → emit bit = one_seen, cnt=0, one_seen=0. This pulse is the next sync.
  - `CELL` with cnt reaching TIMEOUT → emit bit = one_seen, go to `GAP`. A pulse on that same `ce` takes priority and is handled as sync.
- **Byte FSM** (`IDLE`, `HUNT`, `SYNCED`):
  - `motor` rising edge → `HUNT`. ptr=0, overflow=0, shift=0, cell FSM to `GAP`.
  - `HUNT`: each emitted bit is shifted in MSB-first (shift = {shift[6:0], bit}). When shift == SYNC_BYTE, write SYNC_BYTE and go to `SYNCED` with bitcnt=0.
  - `SYNCED`: after 8 bits, write the byte. The state persists across `GAP` periods.
  - `motor` low → `IDLE`. A partial byte is discarded. ptr and rec_len are retained.
- **Writes.** Address is ptr; ptr increments after each write. rec_len = ptr.
  - If ptr == 2^ADDR_W−1 after a write, overflow is set. All later writes are suppressed until the next motor-on.
- **Reset.** Asynchronous, mid-operation. Every register clears immediately. FSMs go to `IDLE` / `GAP`.

## Timing
- Reset values: ram_we=0, ram_a=0, ram_d=0, rec_len=0, busy=0, synced=0, overflow=0.
- Bit decision is registered on the clock edge of the deciding `ce`.
- Byte write:
  - On the edge of the `ce` that completes a byte: ram_we=1, ram_a=ptr, ram_d=byte.
  - On the next clock: ram_we=0, ptr/rec_len +1.
  - ram_we is never high for two consecutive clocks.
- `busy` follows `motor` with one clock latency. `synced` is high only in `SYNCED`.
- Simultaneous motor-off and byte completion: motor-off wins and no write occurs.

## Structure
- Package `eg2000_tape_pkg` holds:
  - state enums for the cell FSM and byte FSM;
  - defaults for SYNC_BYTE, WIN_LO, WIN_HI and TIMEOUT;
  - the counter width constant (13).
- Sub-module `tape_pulse_timer`: the edge detector, saturating counter and cell FSM. Its outputs are a `bit_valid` / `bit_val` pair. The byte FSM and write logic stay in the top.

## Test plan
- Reset asserted mid-byte with ram_we high → all outputs 0 asynchronously; no write after release.
- Motor on; pulse train for 0x00 ×4, then 0xA5, 0x55, then 18000 cycles of silence → writes A5@0, 55@1; rec_len=2; synced=1.
- Pulse at cnt=600 inside a cell → ignored. Pulse at 1791 → bit 1. Pulse at 3582 → sync. Decoded byte is unchanged by the glitch.
- Last cell's data pulse followed by silence → bit emitted at cnt=TIMEOUT. Final byte 0xFF written once.
- ADDR_W=4; stream 20 bytes after sync → 16 writes; overflow=1; no ram_we afterwards. The next motor-on clears overflow and ptr.
- Motor drops after 5 bits of a byte → no write; `IDLE`; rec_len unchanged. Motor rises → rec_len=0; state `HUNT`.
